int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt controller for the 5-stage interrupt pipeline.
- Synchronises raw IRQ lines, latches them as pending, and arbitrates by fixed priority (highest index wins).
- Issues one interrupt-entry request at a time to the pipeline, with a handshake against the WB-stage hidden-instruction retirement.
- Tracks nested in-service interrupts, retires them on URET, and supplies the vector PC.

Parameters:
- NUM_IRQ, 3, number of interrupt lines; bit NUM_IRQ-1 has highest priority.
- WIDTH, 32, PC/vector width.
- VEC0, 32'h000030AC, handler entry for irq[0].
- VEC1, 32'h00003170, handler entry for irq[1].
- VEC2, 32'h00003234, handler entry for irq[2].

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq  in  NUM_IRQ  raw asynchronous request levels (buttons).
- ie  in  1  global interrupt enable (CSR 0x004).
- can_take  in  1  pipeline safe point: ID holds a non-bubble, no CSR write in EX/MEM.
- enter_ack  in  1  WB retires the entry hidden instruction for the current request.
- uret  in  1  WB retires URET.
- int_req  out  1  entry request to ID stage.
- int_id  out  NUM_IRQ  one-hot id of the requested interrupt; stable while int_req=1.
- int_vec  out  WIDTH  handler address for int_id.
- irs  out  NUM_IRQ  one-hot current in-service interrupt (highest bit of ip); 0 if none.
- ip  out  NUM_IRQ  mask of all in-service (nested) interrupts.
- irw  out  NUM_IRQ  pending mask ir, for indicator lamps.
- uret_err  out  1  sticky flag: URET seen with ip==0.

Behaviour:
- Reset (rst=0, async): sync flops, ir, ip, the latched id, uret_err and FSM are all cleared; state=IDLE. Every output is 0 (int_vec=0).
- Synchroniser: 2 flops per line plus an edge register. A rising edge of a synchronised line sets ir[i].
  - Latency: irq edge to ir bit set is 3 clk.
  - A repeated edge while ir[i]=1 is merged, not counted.
  - An edge on a line that is in service sets ir[i] again and is served after that level's URET.
- Candidate cand = highest set bit of (ir & ~ip). Eligible when ie=1, cand!=0, and cand numerically greater than irs (preempt only by higher priority).
- FSM, 2 states:
  - IDLE: int_req=0. If eligible && can_take, latch id=cand and go to REQ on the next edge.
  - REQ: int_req=1; int_id=id; int_vec=VEC[index(id)]. id is frozen; new edges only update ir.
    - On enter_ack: ip|=id, ir&=~id, go to IDLE.
    - If ie=0 and enter_ack=0: withdraw, go to IDLE, ir unchanged.
    - can_take is ignored in REQ; the pipeline commits once ID accepts.
- enter_ack in IDLE: ignored.
- uret in any state: clears the irs bit of ip.
  - If ip==0: no change, and uret_err is set (cleared only by reset).
  - uret and enter_ack in the same cycle: ip_next = (ip & ~irs) | id.
- Edge setting ir[i] and enter_ack clearing ir[i] in the same cycle: the set wins, so the new request is retained.
- int_vec is combinational from the latched id and is 0 when int_req=0.
- irs = highest bit of ip, combinational.
- Arithmetic: only bit masks; no counters wider than NUM_IRQ.

Decomposition:
- Package int_pkg holds:
  - NUM_IRQ default;
  - state encoding (IDLE=1'b0, REQ=1'b1);
  - the vector constant table;
  - function onehot_index (one-hot to index).
- Sub-module prio_onehot: parameterised highest-set-bit selector, outputs a one-hot vector or 0.
  - Instantiated twice: one for cand, one for irs.

Test Plan:
- Reset behaviour: pulse irq=3'b001 with ie=1, can_take=1; assert rst=0 mid-REQ. Required: all outputs 0 asynchronously; after release no req until a new edge.
- Single interrupt: irq[0] edge at cycle 0 with ie=1, can_take=1. Required: ir=001 at cycle 3; int_req=1, int_id=001, int_vec=0x30AC at cycle 4. After enter_ack: ip=001, irs=001, irw=000. After uret: ip=000.
- Simultaneous requests and priority: irq[2] and irq[0] edges in the same cycle. Required: int_id=100, int_vec=0x3234; ack leaves ir=001, and 001 is not requested (lower than irs). After uret, 001 is requested with int_vec=0x30AC.
- Nesting/preemption: in service 001 with ie=1; irq[1] edge. Required: int_id=010, int_vec=0x3170; ack gives ip=011, irs=010. First uret gives ip=001; second gives ip=000.
- Withdraw: in REQ, drop ie to 0 before enter_ack. Required: int_req=0 next cycle and ir unchanged; re-raising ie with can_take=1 reissues the same id.
- Boundary conditions:
  - uret with ip=0: uret_err=1, held until reset.
  - uret and enter_ack together: with ip=001, pending 100 acked, result ip=100.
  - Edge on the acked bit in the ack cycle: ir bit remains 1.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller: FSM encoding,
// the handler vector table and a one-hot to index helper.
package int_pkg;

  localparam int NUM_IRQ_DEF = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  localparam logic [31:0] VEC_TAB [3] = '{32'h000030AC, 32'h00003170, 32'h00003234};

  function automatic logic [2:0] onehot_index(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/int_ctrl_prio_onehot.sv
// Highest-set-bit selector: returns a one-hot vector of the top request, or 0.
module prio_onehot #(
  parameter int W = 3
) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] grant_o
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < W; i++) begin
      if (req_i[i]) begin
        grant_o = W'(1) << i;
      end else begin
        grant_o = grant_o;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises raw IRQ lines, latches pending requests,
// issues one entry request at a time and tracks nested in-service levels.
module int_ctrl
  import int_pkg::*;
#(
  parameter int                 NUM_IRQ = NUM_IRQ_DEF,
  parameter int                 WIDTH   = 32,
  parameter logic [WIDTH-1:0]   VEC0    = VEC_TAB[0],
  parameter logic [WIDTH-1:0]   VEC1    = VEC_TAB[1],
  parameter logic [WIDTH-1:0]   VEC2    = VEC_TAB[2]
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ie,
  input  logic               can_take,
  input  logic               enter_ack,
  input  logic               uret,
  output logic               int_req,
  output logic [NUM_IRQ-1:0] int_id,
  output logic [WIDTH-1:0]   int_vec,
  output logic [NUM_IRQ-1:0] irs,
  output logic [NUM_IRQ-1:0] ip,
  output logic [NUM_IRQ-1:0] irw,
  output logic               uret_err
);

  logic [NUM_IRQ-1:0] sync1_q, sync2_q, edge_q;
  logic [NUM_IRQ-1:0] ir_q, ir_d;
  logic [NUM_IRQ-1:0] ip_q, ip_d;
  logic [NUM_IRQ-1:0] id_q;
  logic               err_q, err_d;
  state_e             state_q;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] irs_w;
  logic [NUM_IRQ-1:0] ack_clr;
  logic               eligible;

  prio_onehot #(.W(NUM_IRQ)) u_cand (
    .req_i   (ir_q & ~ip_q),
    .grant_o (cand)
  );

  prio_onehot #(.W(NUM_IRQ)) u_irs (
    .req_i   (ip_q),
    .grant_o (irs_w)
  );

  assign rise     = sync2_q & ~edge_q;
  assign eligible = ie && (cand != '0) && (cand > irs_w);

  // Two-flop synchroniser plus edge register per line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // Pending/in-service update; a fresh edge beats the ack clear on the same bit.
  always_comb begin
    ack_clr = '0;
    if ((state_q == ST_REQ) && enter_ack) begin
      ack_clr = id_q;
    end else begin
      ack_clr = '0;
    end
    ir_d  = (ir_q & ~ack_clr) | rise;
    ip_d  = ip_q;
    err_d = err_q;
    if (uret) begin
      if (ip_q == '0) begin
        err_d = 1'b1;
      end else begin
        ip_d = ip_q & ~irs_w;
      end
    end else begin
      ip_d = ip_q;
    end
    ip_d = ip_d | ack_clr;
  end

  // Pending, in-service and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q  <= '0;
      ip_q  <= '0;
      err_q <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      ip_q  <= ip_d;
      err_q <= err_d;
    end
  end

  // Request FSM; the latched id stays frozen for the whole REQ phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (eligible && can_take) begin
            id_q    <= cand;
            state_q <= ST_REQ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (enter_ack || !ie) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handler address for the latched id, forced to 0 outside REQ.
  always_comb begin
    int_vec = '0;
    if (state_q == ST_REQ) begin
      case (onehot_index(8'(id_q)))
        3'd0:    int_vec = VEC0;
        3'd1:    int_vec = VEC1;
        3'd2:    int_vec = VEC2;
        default: int_vec = '0;
      endcase
    end else begin
      int_vec = '0;
    end
  end

  assign int_req  = (state_q == ST_REQ);
  assign int_id   = (state_q == ST_REQ) ? id_q : '0;
  assign irs      = irs_w;
  assign ip       = ip_q;
  assign irw      = ir_q;
  assign uret_err = err_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed vector table, reset corner case,
// then randomized traffic against a behavioural model.
module tb_int_ctrl;

  logic       clk, rst;
  logic [2:0] irq;
  logic       ie, can_take, enter_ack, uret;
  logic       int_req;
  logic [2:0] int_id;
  logic [31:0] int_vec;
  logic [2:0] irs, ip, irw;
  logic       uret_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] vtab [3];

  int_ctrl dut (
    .clk(clk), .rst(rst), .irq(irq), .ie(ie), .can_take(can_take),
    .enter_ack(enter_ack), .uret(uret), .int_req(int_req), .int_id(int_id),
    .int_vec(int_vec), .irs(irs), .ip(ip), .irw(irw), .uret_err(uret_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] irq;
    logic       ie, ack, ur;
    logic       req;
    logic [2:0] id, ipx, irwx;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [2:0] i_irq, input logic i_ie, input logic i_ack, input logic i_ur,
                     input logic e_req, input logic [2:0] e_id, input logic [2:0] e_ip,
                     input logic [2:0] e_irw, input logic e_err);
    vec_t v;
    v.irq = i_irq; v.ie = i_ie; v.ack = i_ack; v.ur = i_ur;
    v.req = e_req; v.id = e_id; v.ipx = e_ip; v.irwx = e_irw; v.err = e_err;
    tbl.push_back(v);
  endtask

  function automatic int top_idx(input logic [2:0] m);
    int r;
    r = -1;
    for (int i = 0; i < 3; i++) if (m[i]) r = i;
    return r;
  endfunction

  function automatic logic [2:0] hi1(input logic [2:0] m);
    int t;
    t = top_idx(m);
    return (t < 0) ? 3'b000 : 3'(1 << t);
  endfunction

  task automatic cmp(input string nm, input logic e_req, input logic [2:0] e_id,
                     input logic [2:0] e_ip, input logic [2:0] e_irw, input logic e_err);
    logic [31:0] e_vec;
    logic [2:0]  e_irs;
    int          t;
    e_irs = hi1(e_ip);
    t     = top_idx(e_id);
    e_vec = (e_req && t >= 0) ? vtab[t] : 32'h0;
    total++;
    if ({int_req, int_id, int_vec, irs, ip, irw, uret_err} !==
        {e_req, e_id, e_vec, e_irs, e_ip, e_irw, e_err}) begin
      bad++;
      $display("FAIL %s: got req=%b id=%b vec=%h irs=%b ip=%b irw=%b err=%b want req=%b id=%b vec=%h irs=%b ip=%b irw=%b err=%b",
               nm, int_req, int_id, int_vec, irs, ip, irw, uret_err,
               e_req, e_id, e_vec, e_irs, e_ip, e_irw, e_err);
    end
  endtask

  // Behavioural model state
  logic [2:0] m_pend, m_ip, h1, h2, h3;
  logic       m_req, m_err;
  int         m_idx;

  task automatic model_reset();
    m_pend = 3'b0; m_ip = 3'b0; h1 = 3'b0; h2 = 3'b0; h3 = 3'b0;
    m_req = 1'b0; m_err = 1'b0; m_idx = 0;
  endtask

  task automatic model_step();
    logic [2:0] rise_m;
    int         cand, cur;
    logic       elig, ack;
    rise_m = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = irq;
    cand = top_idx(m_pend & ~m_ip);
    cur  = top_idx(m_ip);
    elig = ie && (cand >= 0) && (cand > cur);
    ack  = m_req && enter_ack;
    if (uret) begin
      if (m_ip == 3'b0) m_err = 1'b1;
      else m_ip[cur] = 1'b0;
    end
    if (ack) begin
      m_ip[m_idx]   = 1'b1;
      m_pend[m_idx] = 1'b0;
    end
    m_pend = m_pend | rise_m;
    if (!m_req) begin
      if (elig && can_take) begin
        m_req = 1'b1;
        m_idx = cand;
      end
    end else if (enter_ack || !ie) begin
      m_req = 1'b0;
    end
  endtask

  initial begin
    int waited;
    bit got;
    vtab[0] = 32'h000030AC; vtab[1] = 32'h00003170; vtab[2] = 32'h00003234;
    irq = 3'b0; ie = 1'b1; can_take = 1'b1; enter_ack = 1'b0; uret = 1'b0;
    rst = 1'b0;

    // irq,ie,ack,uret | req,id,ip,irw,err
    row(3'b001,1,0,0, 0,3'b000,3'b000,3'b000,0);
    row(3'b001,1,0,0, 0,3'b000,3'b000,3'b000,0);
    row(3'b000,1,0,0, 0,3'b000,3'b000,3'b001,0);
    row(3'b000,1,0,0, 1,3'b001,3'b000,3'b001,0);
    row(3'b000,1,1,0, 0,3'b000,3'b001,3'b000,0);
    row(3'b000,1,0,1, 0,3'b000,3'b000,3'b000,0);
    row(3'b101,1,0,0, 0,3'b000,3'b000,3'b000,0);
    row(3'b101,1,0,0, 0,3'b000,3'b000,3'b000,0);
    row(3'b000,1,0,0, 0,3'b000,3'b000,3'b101,0);
    row(3'b000,1,0,0, 1,3'b100,3'b000,3'b101,0);
    row(3'b000,1,1,0, 0,3'b000,3'b100,3'b001,0);
    row(3'b000,1,0,0, 0,3'b000,3'b100,3'b001,0);
    row(3'b000,1,0,1, 0,3'b000,3'b000,3'b001,0);
    row(3'b000,1,0,0, 1,3'b001,3'b000,3'b001,0);
    row(3'b000,1,1,0, 0,3'b000,3'b001,3'b000,0);
    row(3'b010,1,0,0, 0,3'b000,3'b001,3'b000,0);
    row(3'b010,1,0,0, 0,3'b000,3'b001,3'b000,0);
    row(3'b000,1,0,0, 0,3'b000,3'b001,3'b010,0);
    row(3'b000,1,0,0, 1,3'b010,3'b001,3'b010,0);
    row(3'b000,1,1,0, 0,3'b000,3'b011,3'b000,0);
    row(3'b000,1,0,1, 0,3'b000,3'b001,3'b000,0);
    row(3'b000,1,0,1, 0,3'b000,3'b000,3'b000,0);
    row(3'b010,1,0,0, 0,3'b000,3'b000,3'b000,0);
    row(3'b010,1,0,0, 0,3'b000,3'b000,3'b000,0);
    row(3'b000,1,0,0, 0,3'b000,3'b000,3'b010,0);
    row(3'b000,1,0,0, 1,3'b010,3'b000,3'b010,0);
    row(3'b000,0,0,0, 0,3'b000,3'b000,3'b010,0);
    row(3'b000,0,0,0, 0,3'b000,3'b000,3'b010,0);
    row(3'b000,1,0,0, 1,3'b010,3'b000,3'b010,0);
    row(3'b000,1,1,0, 0,3'b000,3'b010,3'b000,0);
    row(3'b000,1,0,1, 0,3'b000,3'b000,3'b000,0);
    row(3'b001,1,0,0, 0,3'b000,3'b000,3'b000,0);
    row(3'b001,1,0,0, 0,3'b000,3'b000,3'b000,0);
    row(3'b000,1,0,0, 0,3'b000,3'b000,3'b001,0);
    row(3'b000,1,0,0, 1,3'b001,3'b000,3'b001,0);
    row(3'b000,1,1,0, 0,3'b000,3'b001,3'b000,0);
    row(3'b100,1,0,0, 0,3'b000,3'b001,3'b000,0);
    row(3'b100,1,0,0, 0,3'b000,3'b001,3'b000,0);
    row(3'b000,1,0,0, 0,3'b000,3'b001,3'b100,0);
    row(3'b000,1,0,0, 1,3'b100,3'b001,3'b100,0);
    row(3'b000,1,1,1, 0,3'b000,3'b100,3'b000,0);
    row(3'b000,1,0,1, 0,3'b000,3'b000,3'b000,0);
    row(3'b001,1,0,0, 0,3'b000,3'b000,3'b000,0);
    row(3'b000,1,0,0, 0,3'b000,3'b000,3'b000,0);
    row(3'b001,1,0,0, 0,3'b000,3'b000,3'b001,0);
    row(3'b000,1,0,0, 1,3'b001,3'b000,3'b001,0);
    row(3'b000,1,1,0, 0,3'b000,3'b001,3'b001,0);
    row(3'b000,1,0,0, 0,3'b000,3'b001,3'b001,0);
    row(3'b000,1,0,1, 0,3'b000,3'b000,3'b001,0);
    row(3'b000,1,0,0, 1,3'b001,3'b000,3'b001,0);
    row(3'b000,1,1,0, 0,3'b000,3'b001,3'b000,0);
    row(3'b000,1,0,1, 0,3'b000,3'b000,3'b000,0);
    row(3'b000,1,0,1, 0,3'b000,3'b000,3'b000,1);
    row(3'b000,1,0,0, 0,3'b000,3'b000,3'b000,1);

    repeat (2) @(negedge clk);
    cmp("reset_state", 0, 3'b000, 3'b000, 3'b000, 0);
    rst = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      irq = tbl[k].irq; ie = tbl[k].ie; enter_ack = tbl[k].ack; uret = tbl[k].ur;
      can_take = 1'b1;
      @(negedge clk);
      cmp($sformatf("row%0d", k), tbl[k].req, tbl[k].id, tbl[k].ipx, tbl[k].irwx, tbl[k].err);
    end
    enter_ack = 1'b0; uret = 1'b0; ie = 1'b1;

    // Async reset in the middle of a request
    irq = 3'b001;
    repeat (2) @(negedge clk);
    irq = 3'b000;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 10) begin
      @(negedge clk);
      waited++;
      got = int_req;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL rst_wait_req: got int_req=0 within %0d cycles, want 1", waited);
    end
    #2 rst = 1'b0;
    #1 cmp("rst_async", 0, 3'b000, 3'b000, 3'b000, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    cmp("rst_no_req_after", 0, 3'b000, 3'b000, 3'b000, 0);

    // Randomized traffic against the model
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 9) == 0) irq[b] = ~irq[b];
      ie        = ($urandom_range(0, 7) != 0);
      can_take  = ($urandom_range(0, 3) != 0);
      enter_ack = ($urandom_range(0, 1) == 1);
      uret      = ($urandom_range(0, 11) == 0);
      @(posedge clk);
      model_step();
      @(negedge clk);
      cmp("rand", m_req, m_req ? 3'(1 << m_idx) : 3'b000, m_ip, m_pend, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
